// File: rtl/jtcop_dial_pkg.sv
// jtcop_dial_pkg
// Shared constants and helpers for the jtcop dial/trackball/rotary bank.
//   DIAL_CNT / DIAL_ROT : per-channel mode encodings (quadrature counter / rotary)
//   CH_MAX / ROTN_MAX   : upper limits for channel count and rotary positions
//   IDX_W               : width of the rotary index register
//   rot_word(idx)       : 16-bit active-low one-hot word for a rotary position
package jtcop_dial_pkg;

    localparam logic DIAL_CNT = 1'b0;
    localparam logic DIAL_ROT = 1'b1;

    localparam int CH_MAX   = 8;
    localparam int ROTN_MAX = 16;
    localparam int IDX_W    = $clog2(ROTN_MAX);

    // Bit idx is cleared, every other bit set. Because idx never reaches
    // ROTN, bits at or above ROTN always read back as 1.
    function automatic logic [15:0] rot_word(input logic [IDX_W-1:0] idx);
        rot_word = ~(16'd1 << idx);
    endfunction

endpackage

// File: rtl/jtcop_dial_ch.sv
// jtcop_dial_ch
// One dial channel: quadrature counter or rotary index, carry flag,
// mode-change detector and the 4701-style read snapshot.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   inc, dec           : direction requests (both or neither = no motion)
//   mode               : 0 = counter, 1 = rotary
//   clr                : clears counter, index and carry
//   step_line          : shared line-prescaler step (counter mode)
//   step_frm           : shared frame-prescaler step (rotary mode)
//   rd_lo              : low-byte read of this channel, loads the snapshot
//   snap_nxt           : next-state snapshot value, used by the output mux
//   carry              : wrap flag, active high
module jtcop_dial_ch
    import jtcop_dial_pkg::*;
#(
    parameter int CW   = 12,
    parameter int ROTN = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        dec,
    input  logic        mode,
    input  logic        clr,
    input  logic        step_line,
    input  logic        step_frm,
    input  logic        rd_lo,
    output logic [15:0] snap_nxt,
    output logic        carry
);

    logic [CW-1:0]    cnt,   cnt_nxt;
    logic [IDX_W-1:0] idx,   idx_nxt;
    logic             carry_nxt;
    logic             mode_l;
    logic [15:0]      snap;
    logic [15:0]      val;
    logic             up, dn, wipe, wrap;

    always_comb begin
        up        = inc & ~dec;
        dn        = dec & ~inc;
        // A mode change behaves exactly like clr so a channel never carries
        // a stale counter into rotary mode or vice versa.
        wipe      = clr | (mode != mode_l);
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        wrap      = 1'b0;
        if (wipe) begin
            cnt_nxt = '0;
            idx_nxt = '0;
        end else if (mode == DIAL_CNT && step_line) begin
            if (up) begin
                cnt_nxt = cnt + CW'(1);
                wrap    = &cnt;
            end else if (dn) begin
                cnt_nxt = cnt - CW'(1);
                wrap    = (cnt == '0);
            end
        end else if (mode == DIAL_ROT && step_frm) begin
            if (up)
                idx_nxt = (idx == IDX_W'(ROTN-1)) ? '0 : idx + IDX_W'(1);
            else if (dn)
                idx_nxt = (idx == '0) ? IDX_W'(ROTN-1) : idx - IDX_W'(1);
        end

        // Clear sources beat a wrap in the same cycle; the snapshot below
        // still sees the wrapped value.
        carry_nxt = carry | wrap;
        if (wipe || rd_lo || mode == DIAL_ROT)
            carry_nxt = 1'b0;

        val      = (mode == DIAL_ROT) ? rot_word(idx_nxt) : 16'(cnt_nxt);
        snap_nxt = rd_lo ? val : snap;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            mode_l <= 1'b0;
            snap   <= '0;
        end else begin
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            carry  <= carry_nxt;
            mode_l <= mode;
            snap   <= snap_nxt;
        end
    end

endmodule

// File: rtl/jtcop_dialbank.sv
// jtcop_dialbank
// Bank of CH dial/trackball/rotary emulators read by the main CPU.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   LVBL, LHBL    : vertical / horizontal blank, active low
//   inc, dec      : per-channel direction requests
//   mode          : per-channel mode (0 counter, 1 rotary)
//   clr           : per-channel clear pulse
//   cs            : CPU read strobe (level)
//   ch_sel        : channel index for the read
//   uln           : byte select (0 low byte + snapshot, 1 high byte)
//   dout          : registered read data
//   cfn           : per-channel carry flag, active low
//
// Read protocol: a read is the rising edge of cs. dout carries the result
// on the following clock and holds it while cs stays high; with cs low
// dout is all ones. Only a low-byte read of a valid channel has side
// effects (snapshot load, carry clear).
module jtcop_dialbank
    import jtcop_dial_pkg::*;
#(
    parameter int CH      = 2,
    parameter int CW      = 12,
    parameter int ROTN    = 12,
    parameter int LINEDIV = 4,
    parameter int FRMDIV  = 8,
    localparam int SW     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          LVBL,
    input  logic          LHBL,
    input  logic [CH-1:0] inc,
    input  logic [CH-1:0] dec,
    input  logic [CH-1:0] mode,
    input  logic [CH-1:0] clr,
    input  logic          cs,
    input  logic [SW-1:0] ch_sel,
    input  logic          uln,
    output logic [15:0]   dout,
    output logic [CH-1:0] cfn
);

    localparam int LW = (LINEDIV > 1) ? $clog2(LINEDIV) : 1;
    localparam int FW = (FRMDIV  > 1) ? $clog2(FRMDIV)  : 1;

    logic          lhbl_l, lvbl_l, cs_l;
    logic [LW-1:0] line_cnt;
    logic [FW-1:0] frm_cnt;
    logic          line_tick, frm_tick, step_line, step_frm, rd_fire;
    logic [CH-1:0] rd_lo;
    logic [CH-1:0] carry;
    logic [15:0]   snap_nxt [CH];
    logic [15:0]   rd_word;

    assign line_tick = lhbl_l & ~LHBL;
    assign frm_tick  = lvbl_l & ~LVBL;
    assign step_line = line_tick && (line_cnt == LW'(LINEDIV-1));
    assign step_frm  = frm_tick  && (frm_cnt  == FW'(FRMDIV-1));
    assign rd_fire   = cs & ~cs_l;
    assign cfn       = ~carry;

    genvar i;
    generate
        for (i = 0; i < CH; i++) begin : g_ch
            assign rd_lo[i] = rd_fire & ~uln & (ch_sel == SW'(i));

            jtcop_dial_ch #(
                .CW   (CW),
                .ROTN (ROTN)
            ) u_ch (
                .clk       (clk),
                .rst_n     (rst_n),
                .inc       (inc[i]),
                .dec       (dec[i]),
                .mode      (mode[i]),
                .clr       (clr[i]),
                .step_line (step_line),
                .step_frm  (step_frm),
                .rd_lo     (rd_lo[i]),
                .snap_nxt  (snap_nxt[i]),
                .carry     (carry[i])
            );
        end
    endgenerate

    // Indices with no matching channel fall through to all ones.
    always_comb begin
        rd_word = 16'hFFFF;
        for (int c = 0; c < CH; c++) begin
            if (ch_sel == SW'(c)) begin
                if (mode[c] == DIAL_ROT)
                    rd_word = snap_nxt[c];
                else
                    rd_word = {8'hFF, uln ? snap_nxt[c][15:8] : snap_nxt[c][7:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lhbl_l   <= 1'b0;
            lvbl_l   <= 1'b0;
            cs_l     <= 1'b0;
            line_cnt <= '0;
            frm_cnt  <= '0;
            dout     <= 16'hFFFF;
        end else begin
            lhbl_l <= LHBL;
            lvbl_l <= LVBL;
            cs_l   <= cs;
            if (line_tick)
                line_cnt <= step_line ? '0 : line_cnt + LW'(1);
            if (frm_tick)
                frm_cnt <= step_frm ? '0 : frm_cnt + FW'(1);
            if (!cs)
                dout <= 16'hFFFF;
            else if (rd_fire)
                dout <= rd_word;
        end
    end

endmodule

// File: tb/tb_jtcop_dialbank.sv
// tb_jtcop_dialbank
// Directed bench for jtcop_dialbank. Three channels are instantiated so an
// out-of-range channel index (3) exists on the 2-bit ch_sel. A behavioural
// model tracks the channels with integer arithmetic and is compared against
// dout/cfn on every falling edge; directed reads also check literal values.
module tb_jtcop_dialbank;

    localparam int CH      = 3;
    localparam int CW      = 12;
    localparam int ROTN    = 12;
    localparam int LINEDIV = 4;
    localparam int FRMDIV  = 8;
    localparam int CNT_MOD = 1 << CW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          LVBL, LHBL;
    logic [CH-1:0] inc, dec, mode, clr;
    logic          cs;
    logic [1:0]    ch_sel;
    logic          uln;
    logic [15:0]   dout;
    logic [CH-1:0] cfn;

    int checks = 0;
    int errors = 0;

    jtcop_dialbank #(
        .CH      (CH),
        .CW      (CW),
        .ROTN    (ROTN),
        .LINEDIV (LINEDIV),
        .FRMDIV  (FRMDIV)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .LVBL   (LVBL),
        .LHBL   (LHBL),
        .inc    (inc),
        .dec    (dec),
        .mode   (mode),
        .clr    (clr),
        .cs     (cs),
        .ch_sel (ch_sel),
        .uln    (uln),
        .dout   (dout),
        .cfn    (cfn)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_cnt  [CH];
    int            m_idx  [CH];
    logic [15:0]   m_snap [CH];
    logic [CH-1:0] m_carry;
    logic [CH-1:0] m_mode_p;
    logic [15:0]   m_dout;
    int            line_n, frm_n;
    logic          lhbl_p, lvbl_p, cs_p;
    logic          m_sl, m_sf, m_rd;
    int            m_d, m_nc;

    function automatic logic [15:0] rot_val(input int pos);
        logic [15:0] v;
        v = 16'hFFFF;
        v[pos] = 1'b0;
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                for (int c = 0; c < CH; c++) begin
                    m_cnt[c]  = 0;
                    m_idx[c]  = 0;
                    m_snap[c] = 16'h0000;
                end
                m_carry  = '0;
                m_mode_p = '0;
                m_dout   = 16'hFFFF;
                line_n   = 0;
                frm_n    = 0;
                lhbl_p   = 1'b0;
                lvbl_p   = 1'b0;
                cs_p     = 1'b0;
            end else begin
                m_sl = 1'b0;
                m_sf = 1'b0;
                if (lhbl_p && !LHBL) begin
                    if (line_n == LINEDIV-1) begin m_sl = 1'b1; line_n = 0; end
                    else line_n++;
                end
                if (lvbl_p && !LVBL) begin
                    if (frm_n == FRMDIV-1) begin m_sf = 1'b1; frm_n = 0; end
                    else frm_n++;
                end
                m_rd = cs && !cs_p;
                for (int c = 0; c < CH; c++) begin
                    m_d = (inc[c] && !dec[c]) ? 1 : (dec[c] && !inc[c]) ? -1 : 0;
                    if (clr[c] || mode[c] != m_mode_p[c]) begin
                        m_cnt[c] = 0; m_idx[c] = 0; m_carry[c] = 1'b0;
                    end else if (!mode[c] && m_sl) begin
                        m_nc = m_cnt[c] + m_d;
                        if (m_nc < 0 || m_nc >= CNT_MOD) m_carry[c] = 1'b1;
                        m_cnt[c] = (m_nc + CNT_MOD) % CNT_MOD;
                    end else if (mode[c] && m_sf) begin
                        m_idx[c] = (m_idx[c] + m_d + ROTN) % ROTN;
                    end
                    if (mode[c]) m_carry[c] = 1'b0;
                    if (m_rd && !uln && int'(ch_sel) == c) begin
                        m_snap[c]  = mode[c] ? rot_val(m_idx[c]) : 16'(m_cnt[c]);
                        m_carry[c] = 1'b0;
                    end
                    m_mode_p[c] = mode[c];
                end
                if (!cs)
                    m_dout = 16'hFFFF;
                else if (m_rd) begin
                    if (int'(ch_sel) >= CH)
                        m_dout = 16'hFFFF;
                    else if (mode[ch_sel])
                        m_dout = m_snap[ch_sel];
                    else
                        m_dout = {8'hFF, uln ? m_snap[ch_sel][15:8] : m_snap[ch_sel][7:0]};
                end
                lhbl_p = LHBL;
                lvbl_p = LVBL;
                cs_p   = cs;
            end
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model.
    initial begin
        repeat (2) @(posedge clk);
        forever begin
            @(negedge clk);
            check("dout_model", dout, m_dout);
            check("cfn_model", {13'b0, cfn}, {13'b0, ~m_carry});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic lines(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk) LHBL = 1'b1;
            @(negedge clk) LHBL = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk) LVBL = 1'b1;
            @(negedge clk) LVBL = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic rd(input int ch, input logic u, input logic [15:0] exp, input string name);
        @(negedge clk);
        cs = 1'b1; ch_sel = 2'(ch); uln = u;
        @(negedge clk);
        check(name, dout, exp);
        @(negedge clk);
        check({name, "_hold"}, dout, exp);
        cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr(input int ch);
        @(negedge clk) clr[ch] = 1'b1;
        @(negedge clk) clr[ch] = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0; LHBL = 1'b0; LVBL = 1'b0;
        inc = '0; dec = '0; mode = '0; clr = '0;
        cs = 1'b0; ch_sel = '0; uln = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_dout", dout, 16'hFFFF);
        check("rst_cfn", {13'b0, cfn}, 16'h0007);
        rst_n = 1'b1;
        rd(0, 1'b0, 16'hFF00, "rst_rd_lo");

        // Counter: two steps up, then three down through zero
        inc[0] = 1'b1;
        lines(8);
        inc[0] = 1'b0;
        check("model_cnt_pin", 16'(m_cnt[0]), 16'h0002);
        rd(0, 1'b0, 16'hFF02, "cnt_up2");
        dec[0] = 1'b1;
        lines(12);
        dec[0] = 1'b0;
        check("cnt_wrap_cfn", {13'b0, cfn}, 16'h0006);
        rd(0, 1'b0, 16'hFFFF, "cnt_wrap_lo");
        check("cnt_rd_clr_cfn", {13'b0, cfn}, 16'h0007);
        rd(0, 1'b1, 16'hFF0F, "cnt_wrap_hi");

        // Snapshot latch: high byte comes from the snap, not the live count
        pulse_clr(0);
        inc[0] = 1'b1;
        lines(255 * LINEDIV);
        inc[0] = 1'b0;
        rd(0, 1'b0, 16'hFFFF, "snap_lo_0ff");
        inc[0] = 1'b1;
        lines(LINEDIV);
        inc[0] = 1'b0;
        rd(0, 1'b1, 16'hFF00, "snap_hi_latched");

        // clr wins over a step and clears a pending carry
        pulse_clr(0);
        dec[0] = 1'b1;
        lines(LINEDIV);
        dec[0] = 1'b0;
        check("carry_set", {13'b0, cfn}, 16'h0006);
        inc[0] = 1'b1;
        lines(LINEDIV - 1);
        @(negedge clk) LHBL = 1'b1;
        @(negedge clk) LHBL = 1'b0; clr[0] = 1'b1;
        @(negedge clk) clr[0] = 1'b0; inc[0] = 1'b0;
        check("clr_prio_cfn", {13'b0, cfn}, 16'h0007);
        rd(0, 1'b0, 16'hFF00, "clr_prio");

        // Wrap and low-byte read on the same cycle
        dec[0] = 1'b1;
        lines(LINEDIV - 1);
        @(negedge clk) LHBL = 1'b1;
        @(negedge clk) LHBL = 1'b0; cs = 1'b1; ch_sel = 2'd0; uln = 1'b0;
        @(negedge clk);
        check("wrap_rd_dout", dout, 16'hFFFF);
        check("wrap_rd_cfn", {13'b0, cfn}, 16'h0007);
        cs = 1'b0; dec[0] = 1'b0;
        @(negedge clk);

        // Rotary: one step down from idx 0 lands on 11
        mode[1] = 1'b1;
        @(negedge clk);
        dec[1] = 1'b1;
        frames(FRMDIV);
        dec[1] = 1'b0;
        rd(1, 1'b0, 16'hF7FF, "rot_dec_lo");
        rd(1, 1'b1, 16'hF7FF, "rot_dec_hi");
        inc[1] = 1'b1; dec[1] = 1'b1;
        frames(2 * FRMDIV);
        inc[1] = 1'b0; dec[1] = 1'b0;
        rd(1, 1'b0, 16'hF7FF, "rot_both_held");
        check("rot_cfn", {13'b0, cfn}, 16'h0007);

        // Mode change clears: counter 0x234 then switch to rotary
        pulse_clr(0);
        inc[0] = 1'b1;
        lines(16'h234 * LINEDIV);
        inc[0] = 1'b0;
        rd(0, 1'b0, 16'hFF34, "cnt_234_lo");
        rd(0, 1'b1, 16'hFF02, "cnt_234_hi");
        mode[0] = 1'b1;
        repeat (2) @(negedge clk);
        rd(0, 1'b0, 16'hFFFE, "mode_toggle");

        // Out-of-range channel: all ones, snapshots untouched
        rd(3, 1'b0, 16'hFFFF, "bound_lo");
        rd(3, 1'b1, 16'hFFFF, "bound_hi");
        rd(1, 1'b1, 16'hF7FF, "bound_snap1");
        rd(0, 1'b1, 16'hFFFE, "bound_snap0");

        // Reset mid-hold: index and prescaler restart
        dec[1] = 1'b1;
        frames(FRMDIV - 1);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_dout", dout, 16'hFFFF);
        check("rst_mid_cfn", {13'b0, cfn}, 16'h0007);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rd(1, 1'b0, 16'hFFFE, "rst_idx0");
        frames(FRMDIV - 1);
        rd(1, 1'b0, 16'hFFFE, "rst_no_step");
        frames(1);
        dec[1] = 1'b0;
        rd(1, 1'b0, 16'hF7FF, "rst_first_step");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
